// File: rtl/memory_pkg.sv
// Instruction memory sizing and shared boot-loader types.
package memory_pkg;

  localparam int unsigned INSTR_MEM_SIZE_WORDS = 64;
  localparam int unsigned INSTR_MEM_SIZE_BYTES = INSTR_MEM_SIZE_WORDS * 4;

  localparam int unsigned LOADER_HDR_BYTES = 4;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    WRITE,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/instr_mem_loader.sv
// Boot loader: receives a length-prefixed little-endian byte image and
// writes it word by word into instruction memory, holding the core in reset.
module instr_mem_loader
  import memory_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic [31:0] write_addr_o,
  output logic [31:0] write_data_o,
  output logic        write_enable_o,
  output logic        core_rst_o,
  output logic        load_done_o,
  output logic        load_error_o,
  input  logic        restart_i
);

  localparam int IDX_W  = $clog2(INSTR_MEM_SIZE_WORDS) + 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  loader_state_t r_state;
  loader_state_t w_next;

  logic [31:0]       r_shift;
  logic [1:0]        r_byte_cnt;
  logic [IDX_W-1:0]  r_n;
  logic [IDX_W-1:0]  r_word_idx;
  logic [IDLE_W-1:0] r_idle;
  logic [31:0]       r_addr;
  logic [31:0]       r_data;
  logic              r_we;

  logic              w_ready;
  logic              w_accept;
  logic              w_last_byte;
  logic [31:0]       w_word;
  logic              w_hdr_bad;
  logic              w_idle_on;
  logic              w_timeout;
  logic              w_restart;
  logic [IDX_W-1:0]  w_idx_inc;

  assign w_accept    = byte_valid_i & w_ready;
  assign w_last_byte = w_accept &
                       (r_byte_cnt == 2'(LOADER_HDR_BYTES - 1));
  assign w_word      = {byte_data_i, r_shift[31:8]};
  assign w_hdr_bad   = (w_word == 32'd0) ||
                       (w_word > 32'(INSTR_MEM_SIZE_WORDS));
  assign w_idle_on   = ((r_state == HDR) && (r_byte_cnt != 2'd0)) ||
                       (r_state == DATA);
  assign w_timeout   = w_idle_on && !w_accept &&
                       (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));
  assign w_restart   = restart_i &&
                       ((r_state == DONE) || (r_state == ERROR));
  assign w_idx_inc   = r_word_idx + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= HDR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    unique case (r_state)
      HDR: begin
        w_ready = 1'b1;
        if (w_timeout)        w_next = ERROR;
        else if (w_last_byte) w_next = w_hdr_bad ? ERROR : DATA;
      end
      DATA: begin
        w_ready = 1'b1;
        if (w_timeout)        w_next = ERROR;
        else if (w_last_byte) w_next = WRITE;
      end
      WRITE:   w_next = (w_idx_inc == r_n) ? DONE : DATA;
      DONE:    if (restart_i) w_next = HDR;
      ERROR:   if (restart_i) w_next = HDR;
      default: w_next = HDR;
    endcase
  end

  // The shift register is shared between header length and payload words.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_n        <= '0;
      r_word_idx <= '0;
      r_idle     <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_we       <= 1'b0;
    end else begin
      r_we <= (w_next == WRITE);
      if (w_restart) begin
        r_shift    <= '0;
        r_byte_cnt <= '0;
        r_n        <= '0;
        r_word_idx <= '0;
        r_idle     <= '0;
      end else begin
        if (w_accept) begin
          r_shift    <= w_word;
          r_byte_cnt <= r_byte_cnt + 2'd1;
          r_idle     <= '0;
        end else if (w_idle_on) begin
          r_idle <= r_idle + 1'b1;
        end
        if ((r_state == HDR) && w_last_byte && !w_hdr_bad) begin
          r_n        <= w_word[IDX_W-1:0];
          r_word_idx <= '0;
        end
        if ((r_state == DATA) && w_last_byte) begin
          r_data <= w_word;
          r_addr <= BASE_ADDR + {{(30-IDX_W){1'b0}}, r_word_idx, 2'b00};
        end
        if (r_state == WRITE) r_word_idx <= w_idx_inc;
      end
    end
  end

  assign byte_ready_o   = w_ready;
  assign write_addr_o   = r_addr;
  assign write_data_o   = r_data;
  assign write_enable_o = r_we;
  assign core_rst_o     = (r_state != DONE);
  assign load_done_o    = (r_state == DONE);
  assign load_error_o   = (r_state == ERROR);

endmodule
